// File: rtl/alu_pipe_param.sv
// Registered WIDTH-bit ALU with valid/ready handshakes and an iterative shift-add multiply.
// Optional SRL/SRA ops are enabled by defining ALU_SHIFT_RIGHT_EN.
module alu_pipe_param #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       ALUop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             Zero,
    output logic             a_bgt_b,
    output logic             illegal_op
);

    localparam int unsigned SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_SLL = 4'b1000;
    localparam logic [3:0] OP_MUL = 4'b1001;
`ifdef ALU_SHIFT_RIGHT_EN
    localparam logic [3:0] OP_SRL = 4'b1010;
    localparam logic [3:0] OP_SRA = 4'b1011;
`endif

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        HOLD
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [SHW-1:0]   cnt;

    logic [WIDTH-1:0] alu_res;
    logic             alu_ill;
    logic [SHW-1:0]   sh;
    logic             accept;
    logic             is_mul;
    logic             mul_last;

    assign in_ready = (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign is_mul   = (ALUop == OP_MUL);
    assign sh       = b[SHW-1:0];
    assign mul_last = (state == BUSY) && (cnt == CNT_LAST);
    assign acc_next = mplier[0] ? acc + mcand : acc;

    // Single-cycle datapath; MUL is produced by the shift-add sequencer instead.
    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case (ALUop)
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_ADD: alu_res = a + b;
            OP_SUB: alu_res = a - b;
            OP_NOR: alu_res = ~(a | b);
            OP_SLL: alu_res = a << sh;
            OP_MUL: alu_res = '0;
`ifdef ALU_SHIFT_RIGHT_EN
            OP_SRL: alu_res = a >> sh;
            OP_SRA: alu_res = $signed(a) >>> sh;
`endif
            default: alu_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept && is_mul) state_next = BUSY;
            BUSY: if (cnt == CNT_LAST) state_next = HOLD;
            HOLD: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            result     <= '0;
            Zero       <= 1'b0;
            a_bgt_b    <= 1'b0;
            illegal_op <= 1'b0;
            mcand      <= '0;
            mplier     <= '0;
            acc        <= '0;
            cnt        <= '0;
        end else if (accept) begin
            Zero    <= (a == b);
            a_bgt_b <= (a > b);
            if (is_mul) begin
                // The previous result may be consumed on this same edge.
                out_valid  <= 1'b0;
                illegal_op <= 1'b0;
                mcand      <= a;
                mplier     <= b;
                acc        <= '0;
                cnt        <= '0;
            end else begin
                out_valid  <= 1'b1;
                result     <= alu_res;
                illegal_op <= alu_ill;
            end
        end else if (state == BUSY) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + SHW'(1);
            if (mul_last) begin
                result    <= acc_next;
                out_valid <= 1'b1;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_pipe_param.sv
// Self-checking bench for alu_pipe_param: directed corner cases plus randomized ops
// against an arithmetic reference model; honours ALU_SHIFT_RIGHT_EN.
module tb_alu_pipe_param;

    localparam int unsigned W = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   ALUop;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         Zero;
    logic         a_bgt_b;
    logic         illegal_op;

    int compared = 0;
    int mismatched = 0;

    alu_pipe_param #(.WIDTH(W)) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a(a),
        .b(b),
        .ALUop(ALUop),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result(result),
        .Zero(Zero),
        .a_bgt_b(a_bgt_b),
        .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: {illegal, result} from the op table using plain arithmetic.
    function automatic logic [W:0] model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        int unsigned s;
        logic [W-1:0] r;
        s = y % W;
        case (op)
            4'b0000: return {1'b0, x & y};
            4'b0001: return {1'b0, x | y};
            4'b0010: return {1'b0, x + y};
            4'b0110: return {1'b0, x - y};
            4'b1100: return {1'b0, ~(x | y)};
            4'b1000: return {1'b0, x << s};
            4'b1001: begin
                r = x * y;
                return {1'b0, r};
            end
`ifdef ALU_SHIFT_RIGHT_EN
            4'b1010: return {1'b0, x >> s};
            4'b1011: begin
                r = x;
                for (int i = 0; i < s; i++) r = {x[W-1], r[W-1:1]};
                return {1'b0, r};
            end
`endif
            default: return {1'b1, {W{1'b0}}};
        endcase
    endfunction

    function automatic logic [W-1:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] x,
                          input logic [W-1:0] y, input int stall);
        logic [W:0]   exp;
        logic [W-1:0] held;
        int           n;
        int           exp_lat;
        logic         busy_ok;
        logic         stable;
        exp     = model(op, x, y);
        exp_lat = (op == 4'b1001) ? W : 0;
        @(negedge clk);
        ALUop     = op;
        a         = x;
        b         = y;
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        #1;
        check({tag, ".in_ready"}, W'(in_ready), W'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = rand64();
        b        = rand64();
        ALUop    = 4'($urandom_range(0, 15));
        n        = 0;
        busy_ok  = 1'b1;
        while (!out_valid && n < 300) begin
            if (in_ready) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, ".latency"}, W'(n), W'(exp_lat));
        check({tag, ".busy_no_ready"}, W'(busy_ok), W'(1));
        check({tag, ".result"}, result, exp[W-1:0]);
        check({tag, ".illegal"}, W'(illegal_op), W'(exp[W]));
        check({tag, ".zero"}, W'(Zero), W'(x == y));
        check({tag, ".bgt"}, W'(a_bgt_b), W'(x > y));
        held = result;
        if (stall > 0) begin
            stable = 1'b1;
            repeat (stall) begin
                @(posedge clk);
                #1;
                if (!out_valid || result !== held || in_ready) stable = 1'b0;
            end
            check({tag, ".stall_stable"}, W'(stable), W'(1));
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        check({tag, ".consumed"}, W'(out_valid), W'(0));
        check({tag, ".result_kept"}, result, held);
    endtask

    initial begin
        logic [W-1:0] exp_r;
        logic         quiet;
        logic [3:0]   rop;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        ALUop     = '0;
        #1;
        check("rst.out_valid", W'(out_valid), W'(0));
        check("rst.result", result, '0);
        check("rst.flags", W'({Zero, a_bgt_b, illegal_op}), W'(0));
        check("rst.in_ready", W'(in_ready), W'(1));
        repeat (2) @(negedge clk);
        reset = 1'b0;

        run_op("add5_7", 4'b0010, 64'd5, 64'd7, 0);
        run_op("sub_ff", 4'b0110, '1, '1, 0);
        run_op("sub_0_1", 4'b0110, 64'd0, 64'd1, 0);
        run_op("sll3_4", 4'b1000, 64'd3, 64'd4, 0);
        run_op("sll3_64", 4'b1000, 64'd3, 64'd64, 0);
        run_op("illegal5", 4'b0101, 64'd9, 64'd2, 0);
        run_op("mul6_7", 4'b1001, 64'd6, 64'd7, 0);
        run_op("mul_wrap", 4'b1001, 64'h8000_0000_0000_0000, 64'd2, 0);
        run_op("mul_stall", 4'b1001, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234_5678_9ABC_DEF1, 3);
        run_op("nor", 4'b1100, 64'h00FF_0000_F0F0_0001, 64'h0F00_0000_0F0F_0000, 0);
        run_op("sra_or_ill", 4'b1011, 64'h8000_0000_0000_0000, 64'd4, 0);
        run_op("srl_or_ill", 4'b1010, 64'hF000_0000_0000_0000, 64'd68, 0);

        // Backpressure, then consume and accept on one edge.
        @(negedge clk);
        ALUop = 4'b0010; a = 64'd100; b = 64'd23; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        quiet = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (!out_valid || result !== 64'd123 || in_ready) quiet = 1'b0;
        end
        check("bp.stable", W'(quiet), W'(1));
        check("bp.bgt", W'(a_bgt_b), W'(1));
        ALUop = 4'b0001; a = 64'hA0; b = 64'h0B; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check("bp.ready_on_release", W'(in_ready), W'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp.new_valid", W'(out_valid), W'(1));
        check("bp.new_result", result, 64'hAB);
        @(posedge clk);
        #1;

        // Reset in the middle of a multiply.
        @(negedge clk);
        ALUop = 4'b1001; a = 64'd5; b = 64'd5; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("midrst.busy", W'(in_ready), W'(0));
        reset = 1'b1;
        #1;
        check("midrst.out_valid", W'(out_valid), W'(0));
        check("midrst.result", result, '0);
        check("midrst.flags", W'({Zero, a_bgt_b, illegal_op}), W'(0));
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst.in_ready", W'(in_ready), W'(1));
        quiet = 1'b1;
        repeat (W + 8) begin
            @(posedge clk);
            #1;
            if (out_valid) quiet = 1'b0;
        end
        check("midrst.no_result", W'(quiet), W'(1));

        for (int i = 0; i < 60; i++) begin
            rop = 4'($urandom_range(0, 15));
            if (i % 10 == 0) rop = 4'b1001;
            if (i % 7 == 3) run_op("rand_eq", rop, exp_r, exp_r, int'($urandom_range(0, 2)));
            else run_op("rand", rop, rand64(), rand64(), int'($urandom_range(0, 2)));
            exp_r = rand64();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
